// File: rtl/display_fill_arbiter.sv
// Arbitrates the display write port between CPU writes (always first) and a rectangle-fill engine.
// Optional macro DISPLAY_FILL_ABORT_EN adds the fillAbort input and fillAborted output.
module display_fill_arbiter #(
    parameter int ROW_BITS   = 7,
    parameter int COL_BITS   = 7,
    parameter int COLOR_BITS = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpuWrite,
    input  logic [ROW_BITS+COL_BITS-1:0] cpuWriteAddress,
    input  logic [COLOR_BITS-1:0]        cpuWriteData,
    input  logic                         fillStart,
    input  logic [COL_BITS-1:0]          fillX0,
    input  logic [COL_BITS-1:0]          fillX1,
    input  logic [ROW_BITS-1:0]          fillY0,
    input  logic [ROW_BITS-1:0]          fillY1,
    input  logic [COLOR_BITS-1:0]        fillColor,
`ifdef DISPLAY_FILL_ABORT_EN
    input  logic                         fillAbort,
    output logic                         fillAborted,
`endif
    output logic                         fillBusy,
    output logic                         fillDone,
    output logic                         write,
    output logic [ROW_BITS+COL_BITS-1:0] writeAddress,
    output logic [COLOR_BITS-1:0]        writeData
);

    localparam int ADDR_BITS = ROW_BITS + COL_BITS;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                  state_q, state_d;
    logic [COL_BITS-1:0]     x0_q, x0_d, x1_q, x1_d, col_q, col_d;
    logic [ROW_BITS-1:0]     y0_q, y0_d, y1_q, y1_d, row_q, row_d;
    logic [COLOR_BITS-1:0]   color_q, color_d;
    logic                    write_q, write_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [COLOR_BITS-1:0]   data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    abortNow;

`ifdef DISPLAY_FILL_ABORT_EN
    logic aborted_q, aborted_d;
    logic abortedOut_q, abortedOut_d;
    assign abortNow    = fillAbort;
    assign fillAborted = abortedOut_q;
`else
    assign abortNow = 1'b0;
`endif

    // Next-state, fill sweep and port mux; CPU write overrides any fill slot
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        col_d   = col_q;
        row_d   = row_q;
        color_d = color_q;
        write_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef DISPLAY_FILL_ABORT_EN
        aborted_d = aborted_q;
`endif
        case (state_q)
            IDLE: begin
                if (fillStart) begin
                    x0_d    = fillX0;
                    x1_d    = fillX1;
                    y0_d    = fillY0;
                    y1_d    = fillY1;
                    color_d = fillColor;
                    col_d   = fillX0;
                    row_d   = fillY0;
`ifdef DISPLAY_FILL_ABORT_EN
                    aborted_d = 1'b0;
`endif
                    state_d = ((fillX0 > fillX1) || (fillY0 > fillY1)) ? DONE : FILL;
                end
            end
            FILL: begin
                if (abortNow) begin
                    state_d = DONE;
`ifdef DISPLAY_FILL_ABORT_EN
                    aborted_d = 1'b1;
`endif
                end else if (!cpuWrite) begin
                    write_d = 1'b1;
                    addr_d  = {row_q, col_q};
                    data_d  = color_q;
                    if (col_q == x1_q && row_q == y1_q) begin
                        state_d = DONE;
                    end else if (col_q == x1_q) begin
                        col_d = x0_q;
                        row_d = row_q + ROW_BITS'(1);
                    end else begin
                        col_d = col_q + COL_BITS'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cpuWrite) begin
            write_d = 1'b1;
            addr_d  = cpuWriteAddress;
            data_d  = cpuWriteData;
        end
        // Status outputs are registered, so they trail the state by one cycle like the write port
        busy_d = (state_d != IDLE) || (state_q != IDLE);
        done_d = (state_q == DONE);
`ifdef DISPLAY_FILL_ABORT_EN
        abortedOut_d = (state_q == DONE) && aborted_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            color_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DISPLAY_FILL_ABORT_EN
            aborted_q    <= 1'b0;
            abortedOut_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            col_q   <= col_d;
            row_q   <= row_d;
            color_q <= color_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DISPLAY_FILL_ABORT_EN
            aborted_q    <= aborted_d;
            abortedOut_q <= abortedOut_d;
`endif
        end
    end

    assign write        = write_q;
    assign writeAddress = addr_q;
    assign writeData    = data_q;
    assign fillBusy     = busy_q;
    assign fillDone     = done_q;

endmodule
